// File: rtl/line_buffer_taps.sv
// line_buffer_taps: multi-line circular delay buffer feeding a windowed kernel stage.
// Every accepted pixel reads all stored lines at its column (read-first) and overwrites
// the oldest line. The next cycle presents one tap per stored line, with validity flags.
`timescale 1ns/1ps
module line_buffer_taps #(
    parameter int DATA_W    = 16,
    parameter int MAX_LINE  = 1280,
    parameter int NUM_LINES = 5,
    parameter int ADDR_W    = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clken,
    input  logic                          sof,
    input  logic [ADDR_W-1:0]             line_len,
    input  logic [DATA_W-1:0]             shiftin,
    output logic [NUM_LINES*DATA_W-1:0]   taps,
    output logic [DATA_W-1:0]             shiftout,
    output logic                          out_valid,
    output logic [NUM_LINES-1:0]          tap_valid,
    output logic [ADDR_W-1:0]             col
);

    localparam int RW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int FW = $clog2(NUM_LINES + 1);
    localparam int MW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
    localparam logic [ADDR_W:0] MAX_LEN  = (ADDR_W+1)'(MAX_LINE);
    localparam logic [RW-1:0]   LAST_ROW = RW'(NUM_LINES - 1);
    localparam logic [FW-1:0]   FULL     = FW'(NUM_LINES);

    logic [DATA_W-1:0] mem_q [NUM_LINES][MAX_LINE];

    logic [ADDR_W-1:0]    c_q, c_d, addr;
    logic [MW-1:0]        ram_addr;
    logic [RW-1:0]        wp_q, wp_d;
    logic [FW-1:0]        fill_q, fill_d, fill_rd;
    // One extra bit so MAX_LINE == 2^ADDR_W is representable; 0 means "never latched".
    logic [ADDR_W:0]      len_q, len_d, len_in, len_use;
    logic                 wrap;
    logic [RW-1:0]        rd_row [NUM_LINES];
    logic [DATA_W-1:0]    taps_q [NUM_LINES];
    logic [NUM_LINES-1:0] tap_valid_q, tap_valid_d;
    logic                 out_valid_q;
    logic [ADDR_W-1:0]    col_q;

    // Clamp the requested line length into 1..MAX_LINE.
    always_comb begin
        len_in = MAX_LEN;
        if (line_len != '0 && {1'b0, line_len} <= MAX_LEN) begin
            len_in = {1'b0, line_len};
        end
    end

    // Column/row/fill next-state; a qualified sof restarts at column 0 with an empty fill.
    always_comb begin
        addr     = sof ? '0 : c_q;
        ram_addr = addr[MW-1:0];
        len_use  = sof ? len_in : ((len_q == '0) ? MAX_LEN : len_q);
        fill_rd  = sof ? '0 : fill_q;
        wrap     = ({1'b0, addr} == len_use - 1'b1);
        c_d      = wrap ? '0 : addr + 1'b1;
        wp_d     = wp_q;
        fill_d   = fill_rd;
        len_d    = sof ? len_in : len_q;
        if (wrap) begin
            wp_d  = (wp_q == LAST_ROW) ? '0 : wp_q + 1'b1;
            len_d = len_in;
            if (fill_rd != FULL) begin
                fill_d = fill_rd + 1'b1;
            end
        end
        for (int k = 0; k < NUM_LINES; k++) begin
            tap_valid_d[k] = (fill_rd > FW'(k));
            if (int'(wp_q) >= k + 1) begin
                rd_row[k] = wp_q - RW'(k + 1);
            end else begin
                rd_row[k] = wp_q + RW'(NUM_LINES - 1 - k);
            end
        end
    end

    // Line storage: not reset, written only on accepted pixels.
    always_ff @(posedge clk) begin
        if (clken) begin
            mem_q[wp_q][ram_addr] <= shiftin;
        end
    end

    // Counters and registered outputs; outputs hold while clken is low except out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q         <= '0;
            wp_q        <= '0;
            fill_q      <= '0;
            len_q       <= '0;
            tap_valid_q <= '0;
            out_valid_q <= 1'b0;
            col_q       <= '0;
            for (int k = 0; k < NUM_LINES; k++) begin
                taps_q[k] <= '0;
            end
        end else begin
            out_valid_q <= clken;
            if (clken) begin
                c_q         <= c_d;
                wp_q        <= wp_d;
                fill_q      <= fill_d;
                len_q       <= len_d;
                tap_valid_q <= tap_valid_d;
                col_q       <= addr;
                for (int k = 0; k < NUM_LINES; k++) begin
                    taps_q[k] <= mem_q[rd_row[k]][ram_addr];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_taps
        assign taps[g*DATA_W +: DATA_W] = taps_q[g];
    end

    assign shiftout  = taps_q[NUM_LINES-1];
    assign out_valid = out_valid_q;
    assign tap_valid = tap_valid_q;
    assign col       = col_q;

endmodule

// File: tb/tb_line_buffer_taps.sv
// Bench for line_buffer_taps: 8-bit pixels, 8-pixel max line, 3 lines.
`timescale 1ns/1ps
module tb_line_buffer_taps;

    localparam int DW = 8;
    localparam int ML = 8;
    localparam int NL = 3;
    localparam int AW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clken;
    logic             sof;
    logic [AW-1:0]    line_len;
    logic [DW-1:0]    shiftin;
    logic [NL*DW-1:0] taps;
    logic [DW-1:0]    shiftout;
    logic             out_valid;
    logic [NL-1:0]    tap_valid;
    logic [AW-1:0]    col;

    line_buffer_taps #(.DATA_W(DW), .MAX_LINE(ML), .NUM_LINES(NL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .clken(clken), .sof(sof), .line_len(line_len),
        .shiftin(shiftin), .taps(taps), .shiftout(shiftout), .out_valid(out_valid),
        .tap_valid(tap_valid), .col(col)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL*DW-1:0] taps;
        logic [NL-1:0]    tv;
        logic [AW-1:0]    col;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t last_exp;

    logic [DW-1:0] m_ram [NL][ML];
    int m_c, m_wp, m_fill, m_len;
    logic [DW-1:0] hist [40];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c = 0; m_wp = 0; m_fill = 0; m_len = 0;
        last_exp = '0;
        sb_q.delete();
    endtask

    // Reference behaviour of one accepted pixel; pushes the output expected next cycle.
    task automatic model_accept(input bit s, input logic [AW-1:0] len, input logic [DW-1:0] pix);
        int   len_in, use_len, addr, fill_rd;
        exp_t e;
        len_in = (len != 0 && int'(len) <= ML) ? int'(len) : ML;
        if (s) begin
            addr = 0; use_len = len_in; fill_rd = 0; m_len = len_in;
        end else begin
            addr = m_c; use_len = (m_len == 0) ? ML : m_len; fill_rd = m_fill;
        end
        for (int k = 0; k < NL; k++) begin
            e.taps[k*DW +: DW] = m_ram[(m_wp + NL - 1 - k) % NL][addr];
            e.tv[k] = (fill_rd > k);
        end
        e.col = AW'(addr);
        m_ram[m_wp][addr] = pix;
        if (addr == use_len - 1) begin
            m_c    = 0;
            m_wp   = (m_wp + 1) % NL;
            m_fill = (fill_rd + 1 > NL) ? NL : fill_rd + 1;
            m_len  = len_in;
        end else begin
            m_c    = addr + 1;
            m_fill = fill_rd;
        end
        sb_q.push_back(e);
    endtask

    // Taps are only meaningful where the expected validity flag is set.
    task automatic compare_out(input exp_t e);
        check_val("col", col, e.col);
        check_val("tap_valid", tap_valid, e.tv);
        for (int k = 0; k < NL; k++) begin
            if (e.tv[k]) check_val($sformatf("tap%0d", k), taps[k*DW +: DW], e.taps[k*DW +: DW]);
        end
        if (e.tv[NL-1]) check_val("shiftout", shiftout, e.taps[(NL-1)*DW +: DW]);
    endtask

    task automatic cycle(input bit en, input bit s, input logic [AW-1:0] len, input logic [DW-1:0] pix);
        exp_t e;
        clken = en; sof = s; line_len = len; shiftin = pix;
        if (en) model_accept(s, len, pix);
        @(posedge clk);
        #1;
        if (en) begin
            check_val("out_valid", out_valid, 1);
            e = sb_q.pop_front();
            compare_out(e);
            last_exp = e;
        end else begin
            check_val("out_valid_idle", out_valid, 0);
            compare_out(last_exp);
        end
    endtask

    initial begin
        rst = 1'b0; clken = 1'b0; sof = 1'b0; line_len = 4; shiftin = '0;
        for (int r = 0; r < NL; r++) for (int c = 0; c < ML; c++) m_ram[r][c] = 'x;
        model_reset();
        #12;
        check_val("rst_taps", taps, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_tap_valid", tap_valid, 0);
        check_val("rst_col", col, 0);
        rst = 1'b1;

        // Continuous stream of 16 pixels, 4-pixel lines.
        for (int i = 1; i <= 16; i++) begin
            cycle(1, i == 1, 4, DW'(i));
            if (i == 5) begin
                check_val("p5_tap0", taps[DW-1:0], 1);
                check_val("p5_tv", tap_valid, 3'b001);
            end
            if (i == 13) begin
                check_val("p13_taps", taps, {8'd1, 8'd5, 8'd9});
                check_val("p13_tv", tap_valid, 3'b111);
                check_val("p13_col", col, 0);
            end
        end

        // Same stream with idle bubbles.
        for (int i = 1; i <= 16; i++) begin
            cycle(1, i == 1, 4, DW'(i));
            if (i == 13) check_val("bub_p13_taps", taps, {8'd1, 8'd5, 8'd9});
            if (i % 3 == 0) cycle(0, 0, 4, 8'hEE);
        end

        // sof in the middle of a line.
        for (int i = 0; i < 6; i++) cycle(1, i == 0, 4, DW'(8'h11 + i));
        cycle(1, 1, 4, 8'hA0);
        check_val("midsof_col", col, 0);
        check_val("midsof_tv", tap_valid, 3'b000);
        for (int i = 1; i <= 4; i++) cycle(1, 0, 4, DW'(8'hA0 + i));
        check_val("midsof_tv4", tap_valid, 3'b001);
        check_val("midsof_tap0", taps[DW-1:0], 8'hA0);

        // Length clamp: 0 and 12 both act as 8.
        for (int i = 0; i < 9; i++) begin
            cycle(1, i == 0, 0, DW'(8'h30 + i));
            if (i == 7) check_val("len0_col7", col, 7);
        end
        check_val("len0_wrap_col", col, 0);
        check_val("len0_wrap_tv", tap_valid, 3'b001);
        for (int i = 0; i < 9; i++) begin
            cycle(1, i == 0, 12, DW'(8'h40 + i));
            if (i == 7) check_val("len12_col7", col, 7);
        end
        check_val("len12_wrap_col", col, 0);
        check_val("len12_wrap_tv", tap_valid, 3'b001);

        // Mid-line length change only affects the next line.
        cycle(1, 1, 4, 8'h50);
        cycle(1, 0, 4, 8'h51);
        cycle(1, 0, 3, 8'h52);
        cycle(1, 0, 3, 8'h53);
        check_val("lenchg_col3", col, 3);
        for (int i = 4; i <= 7; i++) cycle(1, 0, 3, DW'(8'h50 + i));
        check_val("lenchg_wrap3", col, 0);
        check_val("lenchg_tv", tap_valid, 3'b011);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 5; i++) cycle(1, i == 0, 4, DW'(8'h60 + i));
        clken = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_taps", taps, 0);
        check_val("arst_shiftout", shiftout, 0);
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_tap_valid", tap_valid, 0);
        check_val("arst_col", col, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1, 1, 4, 8'h70);
        check_val("post_rst_col", col, 0);
        check_val("post_rst_tv", tap_valid, 0);

        // Saturation over 10 lines.
        for (int i = 0; i < 40; i++) begin
            hist[i] = DW'($urandom_range(0, 255));
            cycle(1, i == 0, 4, hist[i]);
            if (i >= 12) begin
                check_val("sat_shiftout", shiftout, hist[i-12]);
                check_val("sat_tv", tap_valid, 3'b111);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
